cp0_req_unit: RTL and testbench
===============================

// Module: cp0_req_unit
// PURPOSE
//  Coprocessor-0 exception/interrupt unit in the M stage; producer of the Req squash
//  flag that the M-stage register-destination and store-enable muxes consume.
//  Holds SR/Cause/EPC/PRId and decides, in the same cycle, whether the M-stage instruction
//  is taken by an exception or interrupt. Updates state on the following clock edge.
//  Serves mfc0/mtc0/eret and supplies the eret return PC.
// PARAMETERS
//  PRID_VAL  32'h2021_0001  constant returned on reads of PRId (reg 15)
//  RESET_PC  32'h0000_3000  EPC value after reset
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  M_Valid      in   1   M stage holds a real instruction (0 = bubble)
//  M_PC         in   32  PC of the M-stage instruction
//  M_BD         in   1   M-stage instruction sits in a branch delay slot
//  M_ExcCode    in   5   exception code from earlier stages; 0 = none
//  HWInt        in   6   external interrupt lines (level)
//  CP0_WE       in   1   mtc0 in M
//  CP0_Addr     in   5   CP0 register number for read/write
//  CP0_WD       in   32  mtc0 write data
//  EXLClr       in   1   eret in M
//  CP0_RD       out  32  read data for mfc0 (combinational)
//  EPC_O        out  32  current EPC register (eret target)
//  Req          out  1   take exception/interrupt this cycle (combinational)
// BEHAVIOUR
//  Fields: SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}. Unlisted SR bits read 0.
//          Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
//  Reset (reset==0, async): SR=0, Cause=0, EPC=RESET_PC; Req=0 follows from EXL=0/IE=0/ExcCode=0.
//  IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL
//  ExcReq = (M_ExcCode != 0) & !SR.EXL
//  Req    = M_Valid & (IntReq | ExcReq); zero latency, never registered.
//  Priority: interrupt over exception.
//  On posedge with Req=1:
//   - EXL<=1, Cause.BD<=M_BD, Cause.ExcCode<= IntReq ? 5'd0 : M_ExcCode
//   - EPC <= M_BD ? M_PC-32'd4 : M_PC; the subtraction wraps mod 2^32
//  Every posedge: Cause.IP <= HWInt.
//  mtc0 (CP0_WE & !Req): reg 12 writes IM/EXL/IE only; reg 14 writes EPC with [1:0] forced 0.
//   Writes to reg 13/15/others are ignored.
//  EXLClr & !Req: EXL<=0. Req has priority over both mtc0 and EXLClr in the same cycle.
//  Reads: reg 12/13/14/15 give SR/Cause/EPC/PRID_VAL; all others give 0.
//   A read in the same cycle as a write to the same reg returns the old value (no bypass).
//  M_Valid=0 (bubble): Req=0, no CP0 state change except the per-cycle IP update.
//  EXL=1: no new Req, even with ExcCode!=0 or a pending interrupt (nested exceptions are masked).
//  Reset asserted mid-handler clears EXL and EPC immediately, without waiting for clk.
// TESTING
//  1 reset low, then high; read 12/13/14/15 -> 0, 0, 32'h3000, PRID_VAL; Req=0 with HWInt=6'h3F.
//  2 mtc0 SR=32'h0000_0401, HWInt[0]=1, M_PC=32'h3010, M_Valid=1 -> Req=1 same cycle;
//    next cycle EXL=1, ExcCode=0, EPC=32'h3010, Req=0.
//  3 M_ExcCode=5'd12, M_BD=1, M_PC=32'h3024 -> Req=1; next cycle Cause=32'h8000_0030
//    (plus IP bits), EPC=32'h3020.
//  4 EXL=1 with M_ExcCode=4 -> Req=0; then EXLClr=1 -> EXL=0 next cycle, and Req=1 if ExcCode is still 4.
//  5 mtc0 EPC=32'h3007 together with ExcCode=10 -> exception wins: EPC=M_PC, mtc0 data dropped;
//    a lone mtc0 EPC=32'h3007 -> EPC=32'h3004.
//  6 Pull reset low mid-cycle while EXL=1 -> EXL, EPC, Cause clear asynchronously; M_Valid=0 -> Req=0.

Source files
------------

// File: rtl/cp0_req_unit.sv
// cp0_req_unit: M-stage CP0 (SR/Cause/EPC/PRId) with same-cycle exception/interrupt request
module cp0_req_unit #(
    parameter logic [31:0] PRID_VAL = 32'h2021_0001,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_Valid,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        CP0_WE,
    input  logic [4:0]  CP0_Addr,
    input  logic [31:0] CP0_WD,
    input  logic        EXLClr,
    output logic [31:0] CP0_RD,
    output logic [31:0] EPC_O,
    output logic        Req
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic        int_req;
    logic        exc_req;
    logic [31:0] sr;
    logic [31:0] cause;
    always_comb begin
        int_req = |(HWInt & im) & ie & ~exl;
        exc_req = (M_ExcCode != 5'd0) & ~exl;
        Req     = M_Valid & (int_req | exc_req);
        sr      = {16'b0, im, 8'b0, exl, ie};
        cause   = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
        EPC_O   = epc;
        CP0_RD  = CP0_Addr == 5'd12 ? sr :
                  CP0_Addr == 5'd13 ? cause :
                  CP0_Addr == 5'd14 ? epc :
                  CP0_Addr == 5'd15 ? PRID_VAL : 32'd0;
    end
    // A taken request masks any mtc0/eret issued by the squashed instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= RESET_PC;
        end else begin
            ip <= HWInt;
            if (Req) begin
                exl      <= 1'b1;
                bd       <= M_BD;
                exc_code <= int_req ? 5'd0 : M_ExcCode;
                epc      <= M_BD ? M_PC - 32'd4 : M_PC;
            end else begin
                if (CP0_WE && CP0_Addr == 5'd12) begin
                    im  <= CP0_WD[15:10];
                    exl <= CP0_WD[1];
                    ie  <= CP0_WD[0];
                end
                if (CP0_WE && CP0_Addr == 5'd14)
                    epc <= {CP0_WD[31:2], 2'b00};
                if (EXLClr)
                    exl <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cp0_req_unit.sv
// tb_cp0_req_unit: directed vector table, randomized run against a word-level CP0 model, async reset check
module tb_cp0_req_unit;
    localparam logic [31:0] PRID = 32'h2021_0001;
    localparam logic [31:0] RPC  = 32'h0000_3000;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        M_Valid = 1'b0;
    logic [31:0] M_PC = '0;
    logic        M_BD = 1'b0;
    logic [4:0]  M_ExcCode = '0;
    logic [5:0]  HWInt = '0;
    logic        CP0_WE = 1'b0;
    logic [4:0]  CP0_Addr = '0;
    logic [31:0] CP0_WD = '0;
    logic        EXLClr = 1'b0;
    logic [31:0] CP0_RD;
    logic [31:0] EPC_O;
    logic        Req;
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        ec;
    } in_t;
    typedef struct {
        in_t         i;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl[$];
    int cmp = 0;
    int errs = 0;
    logic [31:0] m_sr, m_cause, m_epc;
    cp0_req_unit dut (
        .clk(clk), .reset(reset), .M_Valid(M_Valid), .M_PC(M_PC), .M_BD(M_BD),
        .M_ExcCode(M_ExcCode), .HWInt(HWInt), .CP0_WE(CP0_WE), .CP0_Addr(CP0_Addr),
        .CP0_WD(CP0_WD), .EXLClr(EXLClr), .CP0_RD(CP0_RD), .EPC_O(EPC_O), .Req(Req)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw, input logic we,
                                input logic [4:0] a, input logic [31:0] wd, input logic ec,
                                input logic rq, input logic [31:0] rd, input logic [31:0] ep);
        vec_t r;
        r.i = '{v, pc, bd, exc, hw, we, a, wd, ec};
        r.req = rq;
        r.rd = rd;
        r.epc = ep;
        return r;
    endfunction
    function automatic logic int_pending();
        return (({26'd0, HWInt} << 10) & m_sr & 32'h0000_FC00) != 0 && m_sr[0];
    endfunction
    function automatic logic m_req();
        return M_Valid && !m_sr[1] && (int_pending() || M_ExcCode != 0);
    endfunction
    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction
    task automatic model_reset();
        m_sr = 0;
        m_cause = 0;
        m_epc = RPC;
    endtask
    task automatic model_edge();
        logic take, intr;
        take = m_req();
        intr = int_pending();
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
        if (take) begin
            m_sr = m_sr | 32'd2;
            m_cause = (m_cause & 32'h0000_FC00) | (M_BD ? 32'h8000_0000 : 32'd0)
                      | (intr ? 32'd0 : {27'd0, M_ExcCode} * 4);
            m_epc = M_BD ? M_PC - 4 : M_PC;
        end else begin
            if (CP0_WE && CP0_Addr == 12) m_sr = CP0_WD & 32'h0000_FC03;
            if (CP0_WE && CP0_Addr == 14) m_epc = CP0_WD & ~32'd3;
            if (EXLClr) m_sr = m_sr & ~32'd2;
        end
    endtask
    task automatic drive(input in_t x);
        M_Valid = x.v; M_PC = x.pc; M_BD = x.bd; M_ExcCode = x.exc; HWInt = x.hw;
        CP0_WE = x.we; CP0_Addr = x.a; CP0_WD = x.wd; EXLClr = x.ec;
        @(negedge clk);
    endtask
    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask
    initial begin
        in_t x;
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 12, 32'h0,    0, 0, 32'h0,        RPC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 13, 32'h0,    0, 0, 32'h0,        RPC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 14, 32'h0,    0, 0, RPC,          RPC));
        tbl.push_back(mk(1, 32'h3000, 0, 0,  6'h3F, 0, 15, 32'h0,    0, 0, PRID,         RPC));
        tbl.push_back(mk(1, 32'h3004, 0, 0,  6'h00, 1, 12, 32'h401,  0, 0, 32'h0,        RPC));
        tbl.push_back(mk(1, 32'h3010, 0, 0,  6'h01, 0, 12, 32'h0,    0, 1, 32'h401,      RPC));
        tbl.push_back(mk(1, 32'h3014, 0, 0,  6'h01, 0, 13, 32'h0,    0, 0, 32'h400,      32'h3010));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 12, 32'h0,    1, 0, 32'h403,      32'h3010));
        tbl.push_back(mk(1, 32'h3024, 1, 12, 6'h00, 0, 12, 32'h0,    0, 1, 32'h401,      32'h3010));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 13, 32'h0,    0, 0, 32'h8000_0030, 32'h3020));
        tbl.push_back(mk(1, 32'h3030, 0, 4,  6'h00, 0, 12, 32'h0,    0, 0, 32'h403,      32'h3020));
        tbl.push_back(mk(1, 32'h3030, 0, 4,  6'h00, 0, 14, 32'h0,    1, 0, 32'h3020,     32'h3020));
        tbl.push_back(mk(1, 32'h3040, 0, 4,  6'h00, 0, 12, 32'h0,    0, 1, 32'h401,      32'h3020));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 13, 32'h0,    1, 0, 32'h10,       32'h3040));
        tbl.push_back(mk(1, 32'h3050, 0, 10, 6'h00, 1, 14, 32'h3007, 0, 1, 32'h3040,     32'h3040));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 13, 32'h0,    1, 0, 32'h28,       32'h3050));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 1, 14, 32'h3007, 0, 0, 32'h3050,     32'h3050));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 14, 32'h0,    0, 0, 32'h3004,     32'h3004));
        tbl.push_back(mk(1, 32'h0,    1, 1,  6'h00, 0, 13, 32'h0,    0, 1, 32'h28,       32'h3004));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 1, 15, 32'h0,    0, 0, PRID,         32'hFFFF_FFFC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 1, 13, 32'hFFFF_FFFF, 1, 0, 32'h8000_0004, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 7,  32'h0,    0, 0, 32'h0,        32'hFFFF_FFFC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 12, 32'h0,    0, 0, 32'h401,      32'hFFFF_FFFC));
        tbl.push_back(mk(1, 32'h3060, 0, 7,  6'h01, 0, 13, 32'h0,    0, 1, 32'h8000_0004, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 32'h0,    0, 0,  6'h00, 0, 13, 32'h0,    1, 0, 32'h400,      32'h3060));
        #23 reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        foreach (tbl[k]) begin
            drive(tbl[k].i);
            check($sformatf("row%0d req", k), {31'd0, Req}, {31'd0, tbl[k].req});
            check($sformatf("row%0d rd", k), CP0_RD, tbl[k].rd);
            check($sformatf("row%0d epc", k), EPC_O, tbl[k].epc);
            advance();
        end
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 5));
            x.v   = $urandom_range(0, 3) != 0;
            x.pc  = $urandom & ~32'd3;
            x.bd  = $urandom_range(0, 1) == 1;
            x.exc = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'd0;
            x.hw  = $urandom_range(0, 1) == 1 ? 6'($urandom) : 6'd0;
            x.we  = $urandom_range(0, 3) == 0;
            x.a   = sel < 4 ? 5'(12 + sel) : 5'($urandom);
            x.wd  = $urandom;
            x.ec  = $urandom_range(0, 3) == 0 && !(x.we && x.a == 12);
            drive(x);
            check($sformatf("rnd%0d req", n), {31'd0, Req}, {31'd0, m_req()});
            check($sformatf("rnd%0d rd", n), CP0_RD, m_read(CP0_Addr));
            check($sformatf("rnd%0d epc", n), EPC_O, m_epc);
            advance();
        end
        drive('{0, 0, 0, 0, 0, 1, 12, 32'h0000_FC01, 0});
        advance();
        drive('{1, 32'h3100, 0, 3, 0, 0, 12, 0, 0});
        check("pre-reset req", {31'd0, Req}, {31'd0, m_req()});
        advance();
        drive('{0, 0, 0, 0, 6'h3F, 0, 12, 0, 0});
        check("pre-reset sr", CP0_RD, m_read(12));
        check("pre-reset epc", EPC_O, m_epc);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async req", {31'd0, Req}, 32'd0);
        check("async sr", CP0_RD, m_read(12));
        check("async epc", EPC_O, m_epc);
        CP0_Addr = 13;
        #1;
        check("async cause", CP0_RD, m_read(13));
        HWInt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive('{0, 0, 0, 0, 0, 0, 14, 0, 0});
        check("post-reset epc", CP0_RD, m_read(14));
        advance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
